// File: rtl/crossbar_switch_allocator.sv
// Switch allocator and sequencer for a 5-port (N,S,W,E,L) crossbar.
// Each output port runs a small IDLE/BUSY FSM with a round-robin pointer. Once
// an input wins an output, the path stays locked until that input's tail flit
// has crossed. While the path is locked, the module drives the demux/mux select
// lines and the per-flit grant/valid strobes.
// Direction encoding: N=0, S=1, W=2, E=3, L=4.
module crossbar_switch_allocator #(
  parameter int NPORTS = 5,
  parameter int SEL_W  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             n_req_i,
  input  logic             s_req_i,
  input  logic             w_req_i,
  input  logic             e_req_i,
  input  logic             l_req_i,
  input  logic [SEL_W-1:0] n_dst_i,
  input  logic [SEL_W-1:0] s_dst_i,
  input  logic [SEL_W-1:0] w_dst_i,
  input  logic [SEL_W-1:0] e_dst_i,
  input  logic [SEL_W-1:0] l_dst_i,
  input  logic             n_tail_i,
  input  logic             s_tail_i,
  input  logic             w_tail_i,
  input  logic             e_tail_i,
  input  logic             l_tail_i,
  input  logic             n_out_rdy_i,
  input  logic             s_out_rdy_i,
  input  logic             w_out_rdy_i,
  input  logic             e_out_rdy_i,
  input  logic             l_out_rdy_i,
  output logic             n_gnt_o,
  output logic             s_gnt_o,
  output logic             w_gnt_o,
  output logic             e_gnt_o,
  output logic             l_gnt_o,
  output logic [SEL_W-1:0] n_cs_sel_demux_o,
  output logic [SEL_W-1:0] s_cs_sel_demux_o,
  output logic [SEL_W-1:0] w_cs_sel_demux_o,
  output logic [SEL_W-1:0] e_cs_sel_demux_o,
  output logic [SEL_W-1:0] l_cs_sel_demux_o,
  output logic [SEL_W-1:0] n_cs_sel_mux_o,
  output logic [SEL_W-1:0] s_cs_sel_mux_o,
  output logic [SEL_W-1:0] w_cs_sel_mux_o,
  output logic [SEL_W-1:0] e_cs_sel_mux_o,
  output logic [SEL_W-1:0] l_cs_sel_mux_o,
  output logic             n_out_vld_o,
  output logic             s_out_vld_o,
  output logic             w_out_vld_o,
  output logic             e_out_vld_o,
  output logic             l_out_vld_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Port-indexed views of the per-direction ports (index = direction code)
  logic              req_arr       [NPORTS];
  logic [SEL_W-1:0]  dst_arr       [NPORTS];
  logic              tail_arr      [NPORTS];
  logic              rdy_arr       [NPORTS];

  // Per-input state exported from the input slices
  logic              busy_arr      [NPORTS];
  logic              gnt_arr       [NPORTS];
  logic [SEL_W-1:0]  sel_demux_arr [NPORTS];

  // Per-output state exported from the output slices; *_mat[o][x] refers to input x
  logic [NPORTS-1:0] own_mat       [NPORTS];
  logic [NPORTS-1:0] alloc_mat     [NPORTS];
  logic              xfer_arr      [NPORTS];
  logic              rel_arr       [NPORTS];
  logic [SEL_W-1:0]  sel_mux_arr   [NPORTS];

  assign req_arr[0]  = n_req_i;
  assign req_arr[1]  = s_req_i;
  assign req_arr[2]  = w_req_i;
  assign req_arr[3]  = e_req_i;
  assign req_arr[4]  = l_req_i;
  assign dst_arr[0]  = n_dst_i;
  assign dst_arr[1]  = s_dst_i;
  assign dst_arr[2]  = w_dst_i;
  assign dst_arr[3]  = e_dst_i;
  assign dst_arr[4]  = l_dst_i;
  assign tail_arr[0] = n_tail_i;
  assign tail_arr[1] = s_tail_i;
  assign tail_arr[2] = w_tail_i;
  assign tail_arr[3] = e_tail_i;
  assign tail_arr[4] = l_tail_i;
  assign rdy_arr[0]  = n_out_rdy_i;
  assign rdy_arr[1]  = s_out_rdy_i;
  assign rdy_arr[2]  = w_out_rdy_i;
  assign rdy_arr[3]  = e_out_rdy_i;
  assign rdy_arr[4]  = l_out_rdy_i;

  // ---------------------------------------------------------------------------
  // Output slices: one arbiter + packet-lock FSM per output port
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      state_t            state_reg, state_next;
      logic [SEL_W-1:0]  owner_reg, owner_next;
      logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
      logic [SEL_W-1:0]  winner;
      logic [SEL_W-1:0]  sel_mux;
      logic [NPORTS-1:0] elig;
      logic [NPORTS-1:0] own_vec;
      logic [NPORTS-1:0] alloc_vec;
      logic              found;
      logic              own_req;
      logic              own_tail;
      logic              xfer;
      logic              rel;

      // Eligible requesters: destination matches, input not locked elsewhere, no
      // U-turn. A destination code of 101..111 can never match an output index.
      always_comb begin
        elig = '0;
        for (int x = 0; x < NPORTS; x++) begin
          elig[x] = req_arr[x] && (dst_arr[x] == SEL_W'(gi)) && !busy_arr[x] && (x != gi);
        end
      end

      // Round-robin pick: first eligible input scanning cyclically from rr_ptr
      always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NPORTS; k++) begin
          if (!found && elig[(int'(rr_ptr_reg) + k) % NPORTS]) begin
            found  = 1'b1;
            winner = SEL_W'((int'(rr_ptr_reg) + k) % NPORTS);
          end
        end
      end

      // Live request/tail of the current owner of this output
      always_comb begin
        own_req  = 1'b0;
        own_tail = 1'b0;
        for (int x = 0; x < NPORTS; x++) begin
          if (owner_reg == SEL_W'(x)) begin
            own_req  = req_arr[x];
            own_tail = tail_arr[x];
          end
        end
      end

      assign xfer = (state_reg == ST_BUSY) && own_req && rdy_arr[gi];
      assign rel  = xfer && own_tail;

      // State register: FSM state, owner and round-robin pointer
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_reg  <= ST_IDLE;
          owner_reg  <= '0;
          rr_ptr_reg <= '0;
        end else begin
          state_reg  <= state_next;
          owner_reg  <= owner_next;
          rr_ptr_reg <= rr_ptr_next;
        end
      end

      // Next state: allocate when idle, release when the tail flit crosses
      always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
          ST_IDLE: begin
            if (found) begin
              state_next = ST_BUSY;
              owner_next = winner;
            end
          end
          ST_BUSY: begin
            if (rel) begin
              state_next  = ST_IDLE;
              owner_next  = '0;
              rr_ptr_next = (owner_reg == SEL_W'(NPORTS - 1)) ? '0 : owner_reg + 1'b1;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end

      // Outputs: mux select, ownership and allocation one-hots for the input slices
      always_comb begin
        sel_mux   = '0;
        own_vec   = '0;
        alloc_vec = '0;
        if (state_reg == ST_BUSY) begin
          sel_mux = owner_reg;
          for (int x = 0; x < NPORTS; x++) begin
            own_vec[x] = (owner_reg == SEL_W'(x));
          end
        end else if (found) begin
          for (int x = 0; x < NPORTS; x++) begin
            alloc_vec[x] = (winner == SEL_W'(x));
          end
        end
      end

      assign own_mat[gi]     = own_vec;
      assign alloc_mat[gi]   = alloc_vec;
      assign xfer_arr[gi]    = xfer;
      assign rel_arr[gi]     = rel;
      assign sel_mux_arr[gi] = sel_mux;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Input slices: busy flag, grant and demux select per input port
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
      logic             busy_reg, busy_next;
      logic             alloc_hit;
      logic             rel_hit;
      logic             gnt_c;
      logic [SEL_W-1:0] demux_c;

      // Collect this input's view across outputs; at most one output owns it
      always_comb begin
        alloc_hit = 1'b0;
        rel_hit   = 1'b0;
        gnt_c     = 1'b0;
        demux_c   = '0;
        for (int o = 0; o < NPORTS; o++) begin
          alloc_hit = alloc_hit | alloc_mat[o][gi];
          rel_hit   = rel_hit | (own_mat[o][gi] & rel_arr[o]);
          gnt_c     = gnt_c | (own_mat[o][gi] & xfer_arr[o]);
          if (own_mat[o][gi]) begin
            demux_c = demux_c | SEL_W'(o);
          end
        end
        busy_next = alloc_hit | (busy_reg & ~rel_hit);
      end

      // Busy flag register: set on allocation, cleared when the tail has crossed
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          busy_reg <= 1'b0;
        end else begin
          busy_reg <= busy_next;
        end
      end

      assign busy_arr[gi]      = busy_reg;
      assign gnt_arr[gi]       = gnt_c;
      assign sel_demux_arr[gi] = demux_c;
    end
  endgenerate

  assign n_gnt_o          = gnt_arr[0];
  assign s_gnt_o          = gnt_arr[1];
  assign w_gnt_o          = gnt_arr[2];
  assign e_gnt_o          = gnt_arr[3];
  assign l_gnt_o          = gnt_arr[4];
  assign n_cs_sel_demux_o = sel_demux_arr[0];
  assign s_cs_sel_demux_o = sel_demux_arr[1];
  assign w_cs_sel_demux_o = sel_demux_arr[2];
  assign e_cs_sel_demux_o = sel_demux_arr[3];
  assign l_cs_sel_demux_o = sel_demux_arr[4];
  assign n_cs_sel_mux_o   = sel_mux_arr[0];
  assign s_cs_sel_mux_o   = sel_mux_arr[1];
  assign w_cs_sel_mux_o   = sel_mux_arr[2];
  assign e_cs_sel_mux_o   = sel_mux_arr[3];
  assign l_cs_sel_mux_o   = sel_mux_arr[4];
  assign n_out_vld_o      = xfer_arr[0];
  assign s_out_vld_o      = xfer_arr[1];
  assign w_out_vld_o      = xfer_arr[2];
  assign e_out_vld_o      = xfer_arr[3];
  assign l_out_vld_o      = xfer_arr[4];

endmodule

// File: tb/tb_crossbar_switch_allocator.sv
// Testbench for crossbar_switch_allocator: directed vectors with literal
// expectations, plus a per-cycle comparison against a path-ownership model.
module tb_crossbar_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req  [5];
  logic [2:0] dst  [5];
  logic       tail [5];
  logic       rdy  [5];

  logic       g_n, g_s, g_w, g_e, g_l;
  logic       v_n, v_s, v_w, v_e, v_l;
  logic [2:0] d_n, d_s, d_w, d_e, d_l;
  logic [2:0] m_n, m_s, m_w, m_e, m_l;

  // Packed views ordered {L,E,W,S,N}
  logic [4:0]  gnt_v, vld_v;
  logic [14:0] demux_v, mux_v;
  assign gnt_v   = {g_l, g_e, g_w, g_s, g_n};
  assign vld_v   = {v_l, v_e, v_w, v_s, v_n};
  assign demux_v = {d_l, d_e, d_w, d_s, d_n};
  assign mux_v   = {m_l, m_e, m_w, m_s, m_n};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  crossbar_switch_allocator dut (
    .clk_i(clk), .rst_i(rst),
    .n_req_i(req[0]), .s_req_i(req[1]), .w_req_i(req[2]), .e_req_i(req[3]), .l_req_i(req[4]),
    .n_dst_i(dst[0]), .s_dst_i(dst[1]), .w_dst_i(dst[2]), .e_dst_i(dst[3]), .l_dst_i(dst[4]),
    .n_tail_i(tail[0]), .s_tail_i(tail[1]), .w_tail_i(tail[2]), .e_tail_i(tail[3]), .l_tail_i(tail[4]),
    .n_out_rdy_i(rdy[0]), .s_out_rdy_i(rdy[1]), .w_out_rdy_i(rdy[2]), .e_out_rdy_i(rdy[3]), .l_out_rdy_i(rdy[4]),
    .n_gnt_o(g_n), .s_gnt_o(g_s), .w_gnt_o(g_w), .e_gnt_o(g_e), .l_gnt_o(g_l),
    .n_cs_sel_demux_o(d_n), .s_cs_sel_demux_o(d_s), .w_cs_sel_demux_o(d_w),
    .e_cs_sel_demux_o(d_e), .l_cs_sel_demux_o(d_l),
    .n_cs_sel_mux_o(m_n), .s_cs_sel_mux_o(m_s), .w_cs_sel_mux_o(m_w),
    .e_cs_sel_mux_o(m_e), .l_cs_sel_mux_o(m_l),
    .n_out_vld_o(v_n), .s_out_vld_o(v_s), .w_out_vld_o(v_w), .e_out_vld_o(v_e), .l_out_vld_o(v_l)
  );

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- Model: which input currently holds each output ----------
  int  owner   [5];   // -1 = output free
  int  rr      [5];
  int  nxt_own [5];
  bit  started = 0;

  function automatic bit in_use(input int x);
    for (int o = 0; o < 5; o++) if (owner[o] == x) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin owner[o] = -1; rr[o] = 0; end
    end else begin
      for (int o = 0; o < 5; o++) nxt_own[o] = owner[o];
      // Locked paths: the tail crossing frees the output and moves the pointer past the owner
      for (int o = 0; o < 5; o++) begin
        if (owner[o] >= 0 && req[owner[o]] && rdy[o] && tail[owner[o]]) begin
          nxt_own[o] = -1;
          rr[o] = (owner[o] + 1) % 5;
        end
      end
      // Free outputs: first requester in cyclic order from the pointer
      for (int o = 0; o < 5; o++) begin
        if (owner[o] < 0) begin
          for (int k = 0; k < 5; k++) begin
            if (nxt_own[o] < 0 && req[(rr[o]+k)%5] && int'(dst[(rr[o]+k)%5]) == o
                && (rr[o]+k)%5 != o && !in_use((rr[o]+k)%5))
              nxt_own[o] = (rr[o]+k)%5;
          end
        end
      end
      for (int o = 0; o < 5; o++) owner[o] = nxt_own[o];
    end
    started = 1;
  end

  logic [4:0]  e_gnt, e_vld;
  logic [14:0] e_demux, e_mux;

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      e_gnt = '0; e_vld = '0; e_demux = '0; e_mux = '0;
      for (int o = 0; o < 5; o++) begin
        if (owner[o] >= 0) begin
          e_mux[o*3 +: 3]        = 3'(owner[o]);
          e_demux[owner[o]*3 +: 3] = 3'(o);
          if (req[owner[o]] && rdy[o]) begin
            e_gnt[owner[o]] = 1'b1;
            e_vld[o]        = 1'b1;
          end
        end
      end
      chk("model_gnt", 15'(gnt_v), 15'(e_gnt));
      chk("model_vld", 15'(vld_v), 15'(e_vld));
      chk("model_demux", demux_v, e_demux);
      chk("model_mux", mux_v, e_mux);
    end
  end

  // ---------------- Directed stimulus ----------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      req[i] = 1'b0; dst[i] = 3'd0; tail[i] = 1'b0; rdy[i] = 1'b1;
    end
  endtask

  initial begin
    // Reset held two cycles with every input requesting
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req[i] = 1'b1; dst[i] = 3'((i + 1) % 5); tail[i] = 1'b1; rdy[i] = 1'b1;
    end
    step();
    step();
    chk("rst_gnt", 15'(gnt_v), 15'd0);
    chk("rst_vld", 15'(vld_v), 15'd0);
    chk("rst_demux", demux_v, 15'd0);
    chk("rst_mux", mux_v, 15'd0);
    rst = 1'b0;
    clear_inputs();

    // N -> L multi-flit packet
    req[0] = 1'b1; dst[0] = 3'd4;
    step();
    chk("nl_l_mux", 15'(mux_v[14:12]), 15'd0);
    chk("nl_n_demux", 15'(demux_v[2:0]), 15'd4);
    chk("nl_gnt", 15'(gnt_v), 15'b00001);
    chk("nl_vld", 15'(vld_v), 15'b10000);
    step();
    step();
    tail[0] = 1'b1;
    #1;
    chk("nl_tail_gnt", 15'(gnt_v), 15'b00001);
    step();
    req[0] = 1'b0; tail[0] = 1'b0;
    #1;
    chk("nl_rel_vld", 15'(vld_v), 15'd0);
    chk("nl_rel_demux", 15'(demux_v[2:0]), 15'd0);

    // Pointer on L now at S: S beats N
    req[0] = 1'b1; dst[0] = 3'd4; tail[0] = 1'b1;
    req[1] = 1'b1; dst[1] = 3'd4; tail[1] = 1'b1;
    step();
    chk("rr_l_gnt_s", 15'(gnt_v), 15'b00010);
    chk("rr_l_mux", 15'(mux_v[14:12]), 15'd1);
    step();
    req[1] = 1'b0;
    #1;
    chk("rr_l_bubble", 15'(gnt_v), 15'd0);
    step();
    chk("rr_l_gnt_n", 15'(gnt_v), 15'b00001);
    step();
    clear_inputs();
    step();

    // S, W, E contend for N with single-flit packets
    for (int i = 1; i < 4; i++) begin req[i] = 1'b1; dst[i] = 3'd0; tail[i] = 1'b1; end
    step();
    chk("n_arb_s", 15'(gnt_v), 15'b00010);
    chk("n_arb_mux_s", 15'(mux_v[2:0]), 15'd1);
    step();
    chk("n_arb_bubble", 15'(gnt_v), 15'd0);
    step();
    chk("n_arb_w", 15'(gnt_v), 15'b00100);
    chk("n_arb_mux_w", 15'(mux_v[2:0]), 15'd2);
    step();
    step();
    chk("n_arb_e", 15'(gnt_v), 15'b01000);
    step();
    step();
    chk("n_arb_s2", 15'(gnt_v), 15'b00010);
    step();
    clear_inputs();
    step();

    // N holds E while E's downstream stalls on the tail
    req[0] = 1'b1; dst[0] = 3'd3;
    step();
    chk("hold_first", 15'(gnt_v), 15'b00001);
    chk("hold_first_vld", 15'(vld_v), 15'b01000);
    rdy[3] = 1'b0; tail[0] = 1'b1;
    req[2] = 1'b1; dst[2] = 3'd3; tail[2] = 1'b1;
    repeat (3) begin
      #1;
      chk("hold_gnt", 15'(gnt_v), 15'd0);
      chk("hold_demux", 15'(demux_v[2:0]), 15'd3);
      @(posedge clk);
    end
    #1;
    rdy[3] = 1'b1;
    #1;
    chk("hold_tail_gnt", 15'(gnt_v), 15'b00001);
    chk("hold_tail_vld", 15'(vld_v), 15'b01000);
    step();
    req[0] = 1'b0;
    #1;
    chk("hold_bubble", 15'(gnt_v), 15'd0);
    chk("hold_bubble_demux", 15'(demux_v[2:0]), 15'd0);
    step();
    chk("hold_w_gnt", 15'(gnt_v), 15'b00100);
    chk("hold_w_mux", 15'(mux_v[11:9]), 15'd2);
    step();
    clear_inputs();
    step();

    // Four parallel paths, L U-turn ignored
    req[0] = 1'b1; dst[0] = 3'd1;
    req[1] = 1'b1; dst[1] = 3'd0;
    req[2] = 1'b1; dst[2] = 3'd3;
    req[3] = 1'b1; dst[3] = 3'd2;
    req[4] = 1'b1; dst[4] = 3'd4;
    step();
    chk("par_gnt", 15'(gnt_v), 15'b01111);
    chk("par_vld", 15'(vld_v), 15'b01111);
    chk("par_mux", mux_v, {3'd0, 3'd2, 3'd3, 3'd0, 3'd1});
    chk("par_demux", demux_v, {3'd0, 3'd2, 3'd3, 3'd0, 3'd1});
    step();
    chk("par_gnt2", 15'(gnt_v), 15'b01111);
    for (int i = 0; i < 5; i++) tail[i] = 1'b1;
    step();
    clear_inputs();
    step();

    // Out-of-range destination is never granted
    req[0] = 1'b1; dst[0] = 3'd7;
    repeat (4) begin
      step();
      chk("bad_dst_gnt", 15'(gnt_v), 15'd0);
      chk("bad_dst_vld", 15'(vld_v), 15'd0);
    end
    clear_inputs();
    step();

    // Reset in the middle of a packet, then pointer back at N
    req[0] = 1'b1; dst[0] = 3'd3;
    step();
    chk("mid_rst_pre", 15'(gnt_v), 15'b00001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req[4] = 1'b1; dst[4] = 3'd3;
    #1;
    chk("mid_rst_gnt", 15'(gnt_v), 15'd0);
    chk("mid_rst_vld", 15'(vld_v), 15'd0);
    chk("mid_rst_demux", demux_v, 15'd0);
    chk("mid_rst_mux", mux_v, 15'd0);
    step();
    chk("mid_rst_rr_n", 15'(gnt_v), 15'b00001);
    chk("mid_rst_e_mux", 15'(mux_v[11:9]), 15'd0);
    chk("mid_rst_n_demux", 15'(demux_v[2:0]), 15'd3);
    clear_inputs();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
